axi_scratch_slave: RTL and testbench
====================================

# axi_scratch_slave

Single-beat full-AXI4 slave holding a byte-writable scratchpad of 2^DEPTH_LOG2 words of AXI_DATA_WIDTH bits. Sits directly downstream of the non-bursting AXI master controller, on the far side of the interconnect. It is the target the master exercises for bring-up and loopback: it accepts AW/W/B and AR/R transactions and returns OKAY or DECERR. Bursts are not supported; every transaction is one beat.

## Interface
Parameters:
- AXI_DATA_WIDTH, 512, data bus width; must be a power of two, at least 32
- AXI_ADDR_WIDTH, 34, address width
- DEPTH_LOG2, 6, log2 of the scratchpad word count
- BASE_ADDR, 0, byte base address of the window; aligned to the window size

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESET  in  1  reset
- S_AXI_AWADDR  in  AXI_ADDR_WIDTH  write address
- S_AXI_AWID  in  4  write ID
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  AXI_DATA_WIDTH  write data
- S_AXI_WSTRB  in  AXI_DATA_WIDTH/8  byte enables
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BID  out  4  echoed AWID
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  AXI_ADDR_WIDTH  read address
- S_AXI_ARID  in  4  read ID
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  AXI_DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RID  out  4  echoed ARID
- S_AXI_RLAST  out  1  constant 1
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- err_count  out  16  saturating DECERR count (see Configuration)

Clocking and reset: one clock, S_AXI_ACLK. Reset S_AXI_ARESET is asynchronous and active-high.

## Operation
- Address decode:
  - Byte offset = ADDR − BASE_ADDR.
  - Word index = offset[LSB +: DEPTH_LOG2], where LSB = log2(AXI_DATA_WIDTH/8). Low LSB bits are ignored.
  - Offset ≥ 2^(DEPTH_LOG2+LSB), or ADDR < BASE_ADDR, means out of window.
- Write path: states IDLE, COLLECT, RESP.
  - IDLE/COLLECT: AW and W are captured independently, in any order or in the same cycle. Each ready is high only while its half is not yet captured.
  - Once both halves are held, the commit happens at the next edge:
    - In window: bytes with WSTRB=1 are updated, BRESP=OKAY.
    - Out of window: memory is untouched, BRESP=DECERR.
    - In both cases BID=AWID, BVALID=1, and the state goes to RESP.
  - RESP: AWREADY and WREADY are both 0. On the B handshake, BVALID drops and the state goes to IDLE.
- Read path: states IDLE, RESP.
  - IDLE: ARREADY=1. On the AR handshake, the word is sampled into RDATA and RVALID=1.
    - In window: RRESP=OKAY.
    - Out of window: RDATA=0 and RRESP=DECERR.
    - RID=ARID in both cases.
  - RESP: ARREADY=0. RDATA, RRESP and RID are held stable until the R handshake, then the state returns to IDLE.
- The read and write paths are fully independent and may run concurrently.
- The memory is not reset; its contents are undefined after power-up.

## Timing
- Reset values (asynchronous assert, release synchronous to the clock):
  - AWREADY, WREADY, ARREADY, BVALID, RVALID = 0.
  - BRESP, RRESP, BID, RID = 0. RDATA = 0.
  - Write and read state = IDLE.
  - The readies go to 1 on the first edge after reset is released.
- Write latency: last of the AW/W handshakes in cycle T → BVALID=1 in cycle T+1, with memory updated at the same edge. Readies return to 1 the cycle after the B handshake.
- Read latency: AR handshake in cycle T → RVALID=1 in cycle T+1. ARREADY returns to 1 the cycle after the R handshake.
- Valid signals never depend combinationally on ready inputs. BVALID is held while BREADY=0, and RVALID is held while RREADY=0.
- Same-word collision: if a write commit and an AR handshake fall on the same edge, RDATA returns the pre-write contents.
- Reset mid-transaction: outstanding B and R responses are discarded, and the memory keeps its contents.

## Configuration
- AXI_SCRATCH_ERRCNT_EN defined:
  - err_count increments by 1 for each DECERR on B or R, counted at the commit or sample edge.
  - Simultaneous B and R DECERRs add 2.
  - The count saturates at 16'hFFFF and resets to 0.
- Not defined: err_count is tied to 0 and no counter logic is built.

## Test plan
- Aligned write: AWADDR=BASE+0x40, WDATA=all 0xA5 bytes, WSTRB=all 1 → BRESP=OKAY, BID=AWID. Read of the same address → RDATA=all 0xA5, RRESP=OKAY, RLAST=1.
- W handshake 3 cycles before AW → exactly one B, with BVALID high one cycle after the AW handshake. With BREADY held low for 5 cycles, BVALID stays high and AWREADY/WREADY stay 0.
- WSTRB=only byte 0 set, WDATA byte 0=0x3C, over a word of all 0xA5 → read returns 0x3C in byte 0, and all other bytes read 0xA5.
- Out-of-window write then read (offset = 2^(DEPTH_LOG2+LSB)) → BRESP=2'b11, memory unchanged, RDATA=0, RRESP=2'b11. err_count=2 with the macro, 0 without.
- Write commit to word 5 on the same edge as an AR to word 5 → RDATA=old value. A subsequent read returns the new value.
- Reset asserted while RVALID=1 and RREADY=0 → RVALID=0 immediately and ARREADY=1 one edge after release. Data written earlier is still readable.

Source files
------------

// File: rtl/axi_scratch_slave.sv
// Single-beat AXI4 slave with a byte-writable scratchpad and independent read/write paths.
// Optional saturating DECERR counter enabled by defining AXI_SCRATCH_ERRCNT_EN.
module axi_scratch_slave #(
  parameter int          AXI_DATA_WIDTH = 512,
  parameter int          AXI_ADDR_WIDTH = 34,
  parameter int          DEPTH_LOG2     = 6,
  parameter logic [63:0] BASE_ADDR      = 64'h0
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [3:0]                    S_AXI_AWID,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic [3:0]                    S_AXI_BID,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [3:0]                    S_AXI_ARID,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic [3:0]                    S_AXI_RID,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [15:0]                   err_count
);

  localparam int STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int LSB      = $clog2(STRB_W);
  localparam int WIN_LOG2 = DEPTH_LOG2 + LSB;
  localparam logic [AXI_ADDR_WIDTH-1:0] BASE = BASE_ADDR[AXI_ADDR_WIDTH-1:0];
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_RESP}            r_state_t;

  function automatic logic in_window(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = addr - BASE;
    return (addr >= BASE) && ((off >> WIN_LOG2) == '0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = addr - BASE;
    return DEPTH_LOG2'(off >> LSB);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  // ---------------- write path ----------------
  w_state_t                  w_state, w_state_d;
  logic                      aw_held, aw_held_d, w_held, w_held_d;
  logic                      awready_d, wready_d, bvalid_d;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, cur_addr;
  logic [3:0]                aw_id_q, cur_id;
  logic [AXI_DATA_WIDTH-1:0] w_data_q, cur_data;
  logic [STRB_W-1:0]         w_strb_q, cur_strb;
  logic                      aw_hs, w_hs, aw_have, w_have, commit, w_in_win;
  logic [DEPTH_LOG2-1:0]     w_idx;

  assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
  assign aw_have = aw_held || aw_hs;
  assign w_have  = w_held || w_hs;
  assign commit  = (w_state != W_RESP) && aw_have && w_have;

  // A half captured on an earlier edge comes from its holding register, otherwise from the bus.
  assign cur_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
  assign cur_id   = aw_held ? aw_id_q   : S_AXI_AWID;
  assign cur_data = w_held  ? w_data_q  : S_AXI_WDATA;
  assign cur_strb = w_held  ? w_strb_q  : S_AXI_WSTRB;
  assign w_in_win = in_window(cur_addr);
  assign w_idx    = word_index(cur_addr);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_d = w_state;
    aw_held_d = aw_held;
    w_held_d  = w_held;
    awready_d = S_AXI_AWREADY;
    wready_d  = S_AXI_WREADY;
    bvalid_d  = S_AXI_BVALID;
    case (w_state)
      W_IDLE, W_COLLECT: begin
        if (commit) begin
          w_state_d = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
        end else begin
          aw_held_d = aw_have;
          w_held_d  = w_have;
          awready_d = !aw_have;
          wready_d  = !w_have;
          w_state_d = (aw_have || w_have) ? W_COLLECT : W_IDLE;
        end
      end
      W_RESP: begin
        if (S_AXI_BVALID && S_AXI_BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state       <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_BID     <= '0;
      aw_addr_q     <= '0;
      aw_id_q       <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
    end else begin
      w_state       <= w_state_d;
      aw_held       <= aw_held_d;
      w_held        <= w_held_d;
      S_AXI_AWREADY <= awready_d;
      S_AXI_WREADY  <= wready_d;
      S_AXI_BVALID  <= bvalid_d;
      if (aw_hs) begin
        aw_addr_q <= S_AXI_AWADDR;
        aw_id_q   <= S_AXI_AWID;
      end
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        S_AXI_BRESP <= w_in_win ? RESP_OKAY : RESP_DECERR;
        S_AXI_BID   <= cur_id;
      end
    end
  end

  // NOTE: the storage array has no reset, so its contents survive a mid-transaction reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (commit && w_in_win) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (cur_strb[i]) mem[w_idx][8*i +: 8] <= cur_data[8*i +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t              r_state, r_state_d;
  logic                  arready_d, rvalid_d, ar_hs, r_in_win;
  logic [DEPTH_LOG2-1:0] r_idx;

  assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_in_win    = in_window(S_AXI_ARADDR);
  assign r_idx       = word_index(S_AXI_ARADDR);
  assign S_AXI_RLAST = 1'b1;

  always_comb begin
    r_state_d = r_state;
    arready_d = S_AXI_ARREADY;
    rvalid_d  = S_AXI_RVALID;
    case (r_state)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          r_state_d = R_RESP;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
        end
      end
      R_RESP: begin
        if (S_AXI_RVALID && S_AXI_RREADY) begin
          r_state_d = R_IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Reading mem here with the write on the same edge yields the pre-write word.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RID     <= '0;
    end else begin
      r_state       <= r_state_d;
      S_AXI_ARREADY <= arready_d;
      S_AXI_RVALID  <= rvalid_d;
      if (ar_hs) begin
        S_AXI_RDATA <= r_in_win ? mem[r_idx] : '0;
        S_AXI_RRESP <= r_in_win ? RESP_OKAY : RESP_DECERR;
        S_AXI_RID   <= S_AXI_ARID;
      end
    end
  end

  // ---------------- DECERR counter ----------------
`ifdef AXI_SCRATCH_ERRCNT_EN
  logic [15:0] err_q;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign err_inc = 2'(commit && !w_in_win) + 2'(ar_hs && !r_in_win);
  assign err_sum = {1'b0, err_q} + 17'(err_inc);

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) err_q <= '0;
    else              err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_axi_scratch_slave.sv
// Directed bench for axi_scratch_slave: reset state, writes/reads, strobes, decode errors,
// same-edge collision and reset while a read response is pending.
module tb_axi_scratch_slave;

  localparam int          DW   = 512;
  localparam int          AW   = 34;
  localparam logic [63:0] BASE_P = 64'h1_0000;
  localparam logic [AW-1:0] BASE = 34'h1_0000;
`ifdef AXI_SCRATCH_ERRCNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [AW-1:0]   awaddr = '0, araddr = '0;
  logic [3:0]      awid = '0, arid = '0, bid, rid;
  logic            awvalid = 1'b0, awready, wvalid = 1'b0, wready;
  logic [DW-1:0]   wdata = '0, rdata;
  logic [DW/8-1:0] wstrb = '0;
  logic [1:0]      bresp, rresp;
  logic            bvalid, bready = 1'b0, arvalid = 1'b0, arready;
  logic            rlast, rvalid, rready = 1'b0;
  logic [15:0]     err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_scratch_slave #(
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .DEPTH_LOG2(6), .BASE_ADDR(BASE_P)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWID(awid), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BID(bid), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARID(arid), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RID(rid), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [3:0] id,
                           input logic [DW-1:0] data, input logic [DW/8-1:0] strb,
                           output logic [1:0] resp, output logic [3:0] rbid);
    logic aw_done, w_done, fa, fw;
    int n;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    awaddr = addr; awid = id; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      fa = awvalid && awready;
      fw = wvalid && wready;
      step(); n++;
      if (fa) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (fw) begin wvalid = 1'b0; w_done = 1'b1; end
    end
    bready = 1'b1;
    while (!bvalid && n < 50) begin step(); n++; end
    resp = bresp; rbid = bid;
    step();
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("write_timeout", 1'(n < 50), 1'b1);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [3:0] id,
                          output logic [DW-1:0] data, output logic [1:0] resp,
                          output logic [3:0] rrid, output logic last);
    logic fa;
    int n;
    fa = 1'b0; n = 0;
    araddr = addr; arid = id; arvalid = 1'b1;
    while (!fa && n < 50) begin
      fa = arvalid && arready;
      step(); n++;
    end
    arvalid = 1'b0;
    rready = 1'b1;
    while (!rvalid && n < 50) begin step(); n++; end
    data = rdata; resp = rresp; rrid = rid; last = rlast;
    step();
    rready = 1'b0;
    chk("read_timeout", 1'(n < 50), 1'b1);
  endtask

  logic [DW-1:0] rd;
  logic [1:0]    rs;
  logic [3:0]    id_o;
  logic          last;
  logic [DW-1:0] pat_a5, pat_5a, pat_w2, pat_11, pat_77, pat_99, exp_strb;

  initial begin
    pat_a5 = {64{8'hA5}};
    pat_5a = {64{8'h5A}};
    pat_w2 = {16{32'h1234_5678}};
    pat_11 = {64{8'h11}};
    pat_77 = {64{8'h77}};
    pat_99 = {64{8'h99}};
    exp_strb = {{63{8'hA5}}, 8'h3C};

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready",  wready,  1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid",  bvalid,  1'b0);
    chk("rst_rvalid",  rvalid,  1'b0);
    chk("rst_rdata",   rdata,   '0);
    chk("rst_errcnt",  err_count, 16'h0);
    @(posedge clk); #1;
    chk("rst_held_ready", awready, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_awready", awready, 1'b1);
    chk("post_rst_wready",  wready,  1'b1);
    chk("post_rst_arready", arready, 1'b1);

    // Aligned full write and read-back
    axi_write(BASE + 34'h40, 4'h3, pat_a5, '1, rs, id_o);
    chk("wr_bresp", rs, 2'b00);
    chk("wr_bid",   id_o, 4'h3);
    axi_read(BASE + 34'h40, 4'h6, rd, rs, id_o, last);
    chk("rd_data",  rd, pat_a5);
    chk("rd_rresp", rs, 2'b00);
    chk("rd_rid",   id_o, 4'h6);
    chk("rd_rlast", last, 1'b1);

    // W handshake three cycles before AW, then B held off for five cycles
    wdata = pat_w2; wstrb = '1; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("wfirst_wready", wready, 1'b0);
    chk("wfirst_awready", awready, 1'b1);
    step();
    chk("wfirst_nob1", bvalid, 1'b0);
    step();
    chk("wfirst_nob2", bvalid, 1'b0);
    awaddr = BASE + 34'h80; awid = 4'h9; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("wfirst_bvalid", bvalid, 1'b1);
    chk("wfirst_bid", bid, 4'h9);
    chk("wfirst_bresp", bresp, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bhold_bvalid", bvalid, 1'b1);
      chk("bhold_readies", {awready, wready}, 2'b00);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bdone_bvalid", bvalid, 1'b0);
    chk("bdone_readies", {awready, wready}, 2'b11);
    step();
    chk("single_b", bvalid, 1'b0);
    axi_read(BASE + 34'h80, 4'h1, rd, rs, id_o, last);
    chk("wfirst_readback", rd, pat_w2);

    // Single-byte strobe over the all-0xA5 word
    axi_write(BASE + 34'h40, 4'h2, {pat_5a[DW-1:8], 8'h3C}, 64'h1, rs, id_o);
    chk("strb_bresp", rs, 2'b00);
    axi_read(BASE + 34'h40, 4'h2, rd, rs, id_o, last);
    chk("strb_data", rd, exp_strb);

    // Out-of-window write leaves word 0 (its alias) untouched; reads decode-error
    axi_write(BASE, 4'h4, pat_11, '1, rs, id_o);
    axi_write(BASE + 34'h1000, 4'h5, '1, '1, rs, id_o);
    chk("oow_bresp", rs, 2'b11);
    chk("oow_bid", id_o, 4'h5);
    axi_read(BASE + 34'h1000, 4'h7, rd, rs, id_o, last);
    chk("oow_rdata", rd, '0);
    chk("oow_rresp", rs, 2'b11);
    chk("oow_rid", id_o, 4'h7);
    chk("oow_errcnt", err_count, 16'(2 * ERR_EN));
    axi_read(BASE, 4'h7, rd, rs, id_o, last);
    chk("oow_mem_kept", rd, pat_11);
    axi_read(BASE - 34'h40, 4'h8, rd, rs, id_o, last);
    chk("below_base_rresp", rs, 2'b11);
    chk("below_base_errcnt", err_count, 16'(3 * ERR_EN));

    // Write commit and AR on the same edge to word 5
    axi_write(BASE + 34'h140, 4'h1, pat_77, '1, rs, id_o);
    awaddr = BASE + 34'h140; awid = 4'hA; wdata = pat_99; wstrb = '1;
    araddr = BASE + 34'h140; arid = 4'hB;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("coll_bvalid", bvalid, 1'b1);
    chk("coll_rvalid", rvalid, 1'b1);
    chk("coll_old_data", rdata, pat_77);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    chk("coll_done", {bvalid, rvalid}, 2'b00);
    axi_read(BASE + 34'h140, 4'hC, rd, rs, id_o, last);
    chk("coll_new_data", rd, pat_99);

    // Reset while a read response is pending
    araddr = BASE + 34'h40; arid = 4'hD; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    step();
    chk("pend_rvalid", rvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_rvalid", rvalid, 1'b0);
    chk("midrst_arready", arready, 1'b0);
    #2 rst = 1'b0;
    step();
    chk("midrst_arready_back", arready, 1'b1);
    chk("midrst_no_rvalid", rvalid, 1'b0);
    axi_read(BASE + 34'h40, 4'hE, rd, rs, id_o, last);
    chk("midrst_mem_kept", rd, exp_strb);
    chk("midrst_errcnt", err_count, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
